// File: rtl/float_addsub_seq.sv
// Multicycle IEEE-754 adder/subtractor with valid/ready handshakes on both sides.
// One operation in flight: accept, align, add, normalise (n cycles), round, hold result.
// Subnormal operands are flushed to signed zero; results below the normal range flush to zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// ALIGN | unpack, resolve specials, swap and align the smaller operand
// ADD   | magnitude add/subtract, carry fix-up, exact-zero detect
// NORM  | one left shift per cycle until the hidden bit is set
// ROUND | round-to-nearest-even, overflow to infinity
// DONE  | result held; out_valid rises the cycle after entry and drops on handshake
module float_addsub_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   op_a,
    input  logic [EXP_W+FRAC_W:0]   op_b,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [3:0]              flags
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    // mantissa field: carry | hidden | frac | guard | round
    localparam int MW = FRAC_W + 4;
    localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]   a_q, b_q;
    logic           sign_q, eff_sub_q, sticky_q;
    logic [EXP_W:0] exp_q;
    logic [MW-1:0]  mant_q, small_q;
    logic [W-1:0]   result_q;
    logic [3:0]     flags_q;
    logic           out_valid_q;

    // operand unpacking
    logic               a_s, b_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]   a_e, b_e;
    logic [FRAC_W-1:0]  a_f, b_f;
    logic [W-2:0]       a_mag, b_mag;

    // alignment
    logic               swap, big_s, al_sticky;
    logic [EXP_W-1:0]   big_e, small_e, sh_amt;
    logic [MW-1:0]      a_m, b_m, big_m, small_m, small_sh;

    // special-value resolution
    logic               spec_hit, spec_inv;
    logic [W-1:0]       spec_res;

    // add stage
    logic [MW-1:0]      add_sum, add_dif, add_mant;
    logic [EXP_W:0]     add_exp;
    logic               add_sticky, add_zero;

    // normalise stage
    logic [MW-1:0]      norm_mant;
    logic [EXP_W:0]     norm_exp;
    logic               norm_unf;

    // round stage
    logic               rnd_up, rnd_inexact, rnd_ovf;
    logic [FRAC_W+1:0]  rounded;
    logic [FRAC_W-1:0]  rnd_frac;
    logic [EXP_W:0]     rnd_exp;
    logic [W-1:0]       rnd_res;

    // unpack captured operands, flushing subnormals to zero
    always_comb begin
        a_s    = a_q[W-1];
        b_s    = b_q[W-1];
        a_e    = a_q[W-2:FRAC_W];
        b_e    = b_q[W-2:FRAC_W];
        a_f    = a_q[FRAC_W-1:0];
        b_f    = b_q[FRAC_W-1:0];
        a_zero = (a_e == '0);
        b_zero = (b_e == '0);
        a_inf  = (&a_e) && (a_f == '0);
        b_inf  = (&b_e) && (b_f == '0);
        a_nan  = (&a_e) && (a_f != '0);
        b_nan  = (&b_e) && (b_f != '0);
        a_mag  = a_zero ? '0 : {a_e, a_f};
        b_mag  = b_zero ? '0 : {b_e, b_f};
        a_m    = a_zero ? '0 : {1'b0, 1'b1, a_f, 2'b00};
        b_m    = b_zero ? '0 : {1'b0, 1'b1, b_f, 2'b00};
    end

    // order by magnitude and right-shift the smaller mantissa, collecting sticky
    always_comb begin
        swap      = (b_mag > a_mag);
        big_s     = swap ? b_s : a_s;
        big_e     = swap ? b_e : a_e;
        small_e   = swap ? a_e : b_e;
        big_m     = swap ? b_m : a_m;
        small_m   = swap ? a_m : b_m;
        sh_amt    = big_e - small_e;
        small_sh  = small_m >> sh_amt;
        al_sticky = |(small_m & ~({MW{1'b1}} << sh_amt));
    end

    // NaN, infinity and double-zero cases bypass the arithmetic
    always_comb begin
        spec_hit = 1'b0;
        spec_inv = 1'b0;
        spec_res = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            spec_hit = 1'b1;
            spec_inv = 1'b1;
            spec_res = QNAN;
        end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_res = {a_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (b_inf) begin
            spec_hit = 1'b1;
            spec_res = {b_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_hit = 1'b1;
            spec_res = {a_s & b_s, {(W-1){1'b0}}};
        end
    end

    // magnitude add or subtract; sticky acts as a borrow below the round bit
    always_comb begin
        add_sum    = mant_q + small_q;
        add_dif    = mant_q - small_q - {{(MW-1){1'b0}}, sticky_q};
        add_mant   = add_dif;
        add_exp    = exp_q;
        add_sticky = sticky_q;
        add_zero   = 1'b0;
        if (!eff_sub_q) begin
            if (add_sum[MW-1]) begin
                add_mant   = add_sum >> 1;
                add_sticky = sticky_q | add_sum[0];
                add_exp    = exp_q + EXP_ONE;
            end else begin
                add_mant = add_sum;
            end
        end else begin
            add_zero = (add_dif == '0) && !sticky_q;
        end
    end

    // single-step normalisation with underflow detection
    always_comb begin
        norm_mant = mant_q << 1;
        norm_exp  = exp_q - EXP_ONE;
        norm_unf  = (norm_exp == '0);
    end

    // round to nearest, ties to even
    always_comb begin
        rnd_up      = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
        rnd_inexact = mant_q[1] | mant_q[0] | sticky_q;
        rounded     = {1'b0, mant_q[MW-2:2]} + {{(FRAC_W+1){1'b0}}, rnd_up};
        rnd_exp     = exp_q + {{EXP_W{1'b0}}, rounded[FRAC_W+1]};
        rnd_frac    = rounded[FRAC_W+1] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
        rnd_ovf     = (rnd_exp >= EXP_MAX);
        rnd_res     = rnd_ovf ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                              : {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ALIGN;
            ALIGN:   state_d = spec_hit ? DONE : ADD;
            ADD: begin
                if (add_zero)              state_d = DONE;
                else if (add_mant[MW-2])   state_d = ROUND;
                else                       state_d = NORM;
            end
            NORM: begin
                if (norm_unf)              state_d = DONE;
                else if (norm_mant[MW-2])  state_d = ROUND;
            end
            ROUND:   state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath registers advanced per state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            sticky_q  <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            small_q   <= '0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= op_a;
                    b_q     <= {op_b[W-1] ^ sub, op_b[W-2:0]};
                    flags_q <= '0;
                end
                ALIGN: begin
                    if (spec_hit) begin
                        result_q   <= spec_res;
                        flags_q[3] <= spec_inv;
                    end else begin
                        sign_q    <= big_s;
                        eff_sub_q <= a_s ^ b_s;
                        exp_q     <= {1'b0, big_e};
                        mant_q    <= big_m;
                        small_q   <= small_sh;
                        sticky_q  <= al_sticky;
                    end
                end
                ADD: begin
                    mant_q   <= add_mant;
                    exp_q    <= add_exp;
                    sticky_q <= add_sticky;
                    if (add_zero) result_q <= '0;
                end
                NORM: begin
                    mant_q <= norm_mant;
                    exp_q  <= norm_exp;
                    if (norm_unf) begin
                        result_q   <= {sign_q, {(W-1){1'b0}}};
                        flags_q[1] <= 1'b1;
                        flags_q[0] <= 1'b1;
                    end
                end
                ROUND: begin
                    result_q   <= rnd_res;
                    flags_q[2] <= rnd_ovf;
                    flags_q[0] <= rnd_inexact | rnd_ovf;
                end
                default: ;
            endcase
        end
    end

    // out_valid presents the held result one cycle after DONE is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_valid_q <= 1'b0;
        else
            out_valid_q <= (state_q == DONE) && !(out_valid_q && out_ready);
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
